// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback
// sources, with a registered write stage and a pending-write scoreboard for RAW stalls.
module regfile_wb_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*XLEN-1:0]       req_data,
  input  logic                          issue_valid,
  input  logic [REG_ADDR_W-1:0]         issue_rd,
  input  logic [REG_ADDR_W-1:0]         rs1,
  input  logic [REG_ADDR_W-1:0]         rs2,
  output logic                          rf_reg_write,
  output logic [REG_ADDR_W-1:0]         rf_rd,
  output logic [XLEN-1:0]               rf_write_data,
  output logic [31:0]                   busy_vec,
  output logic                          hazard
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]   NUM_REQ_W  = (PTR_W + 1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NUM_REQ - 1);
  localparam logic [REG_ADDR_W-1:0] RD_ZERO = {REG_ADDR_W{1'b0}};

  logic [PTR_W-1:0]      rr_ptr_r;
  logic [NUM_REQ-1:0]    grant_s;
  logic                  grant_any_s;
  logic [PTR_W-1:0]      winner_s;
  logic [PTR_W:0]        idx_s;
  logic [REG_ADDR_W-1:0] win_rd_s;
  logic [XLEN-1:0]       win_data_s;
  logic [31:0]           busy_r;
  logic [31:0]           set_mask_s;
  logic [31:0]           clr_mask_s;

  // Round-robin scan from rr_ptr plus one-hot mux of the winner's rd/data.
  always_comb begin
    grant_s     = {NUM_REQ{1'b0}};
    grant_any_s = 1'b0;
    winner_s    = {PTR_W{1'b0}};
    idx_s       = {(PTR_W + 1){1'b0}};
    win_rd_s    = RD_ZERO;
    win_data_s  = {XLEN{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = {1'b0, rr_ptr_r} + (PTR_W + 1)'(k);
      if (idx_s >= NUM_REQ_W) begin
        idx_s = idx_s - NUM_REQ_W;
      end else begin
        idx_s = idx_s;
      end
      // Grants are suppressed while reset is held so nothing is acknowledged and then lost.
      if (!rst && !grant_any_s && req_valid[idx_s[PTR_W-1:0]]) begin
        grant_any_s                 = 1'b1;
        winner_s                    = idx_s[PTR_W-1:0];
        grant_s[idx_s[PTR_W-1:0]]   = 1'b1;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i]) begin
        win_rd_s   = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
        win_data_s = req_data[i*XLEN +: XLEN];
      end else begin
        win_rd_s   = win_rd_s;
      end
    end
  end

  assign req_ready = grant_s;

  // Registered write stage and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_reg_write  <= 1'b0;
      rf_rd         <= RD_ZERO;
      rf_write_data <= {XLEN{1'b0}};
      rr_ptr_r      <= {PTR_W{1'b0}};
    end else if (grant_any_s) begin
      rr_ptr_r     <= (winner_s == LAST_IDX) ? {PTR_W{1'b0}} : winner_s + PTR_W'(1);
      rf_reg_write <= (win_rd_s != RD_ZERO);
      // x0 writes are swallowed; rd/data keep their previous value.
      if (win_rd_s != RD_ZERO) begin
        rf_rd         <= win_rd_s;
        rf_write_data <= win_data_s;
      end
    end else begin
      rf_reg_write <= 1'b0;
    end
  end

  assign set_mask_s = (issue_valid && issue_rd != RD_ZERO) ? (32'd1 << issue_rd) : 32'd0;
  assign clr_mask_s = (rf_reg_write && rf_rd != RD_ZERO) ? (32'd1 << rf_rd) : 32'd0;

  // Scoreboard: a new issue beats a same-cycle writeback to the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 32'd0;
    end else begin
      busy_r <= ((busy_r & ~clr_mask_s) | set_mask_s) & ~32'd1;
    end
  end

  assign busy_vec = busy_r;
  assign hazard   = (rs1 != RD_ZERO && busy_r[rs1]) || (rs2 != RD_ZERO && busy_r[rs2]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (3 requesters, 32-bit data).
module tb_regfile_wb_arbiter;
  localparam int NUM_REQ = 3;
  localparam int XLEN    = 32;
  localparam int AW      = 5;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*AW-1:0]    req_rd;
  logic [NUM_REQ*XLEN-1:0]  req_data;
  logic                     issue_valid;
  logic [AW-1:0]            issue_rd;
  logic [AW-1:0]            rs1;
  logic [AW-1:0]            rs2;
  logic                     rf_reg_write;
  logic [AW-1:0]            rf_rd;
  logic [XLEN-1:0]          rf_write_data;
  logic [31:0]              busy_vec;
  logic                     hazard;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2), .rf_reg_write(rf_reg_write),
    .rf_rd(rf_rd), .rf_write_data(rf_write_data), .busy_vec(busy_vec), .hazard(hazard)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
    req_rd[i*AW +: AW]       = rd;
    req_data[i*XLEN +: XLEN] = data;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 3'b000; req_rd = '0; req_data = '0;
    issue_valid = 1'b0; issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    step(); step();
    checks++; if (rf_reg_write !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", rf_reg_write); end
    checks++; if (rf_rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d expected 0", rf_rd); end
    checks++; if (rf_write_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", rf_write_data); end
    checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy_vec); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b expected 0", hazard); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    set_req(1, 5'd5, 32'hDEADBEEF);
    set_req(0, 5'd1, 32'h1);
    set_req(2, 5'd2, 32'h2);
    req_valid = 3'b010;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_ready: got %b expected 010", req_ready); end
    step();
    req_valid = 3'b000;
    checks++; if (rf_reg_write !== 1'b1) begin errors++; $display("FAIL single_we: got %b expected 1", rf_reg_write); end
    checks++; if (rf_rd !== 5'd5) begin errors++; $display("FAIL single_rd: got %0d expected 5", rf_rd); end
    checks++; if (rf_write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h expected deadbeef", rf_write_data); end
    #1;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL single_idle_ready: got %b expected 000", req_ready); end
    step();
    checks++; if (rf_reg_write !== 1'b0) begin errors++; $display("FAIL single_we_drop: got %b expected 0", rf_reg_write); end
    checks++; if (rf_rd !== 5'd5) begin errors++; $display("FAIL single_rd_hold: got %0d expected 5", rf_rd); end
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] exp_grant;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, AW'(10 + i), 32'hA0 + 32'(i));
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      exp_grant = 3'b001 << (c % 3);
      #1;
      checks++; if (req_ready !== exp_grant) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", c, req_ready, exp_grant); end
      step();
      checks++;
      if (rf_reg_write !== 1'b1 || rf_rd !== AW'(10 + c % 3) || rf_write_data !== 32'hA0 + 32'(c % 3)) begin
        errors++;
        $display("FAIL rr_write%0d: got we=%b rd=%0d data=%h expected we=1 rd=%0d data=%h",
                 c, rf_reg_write, rf_rd, rf_write_data, 10 + c % 3, 32'hA0 + 32'(c % 3));
      end
    end
    req_valid = 3'b000;
  endtask

  task automatic test_x0();
    issue_valid = 1'b1; issue_rd = 5'd3;
    set_req(0, 5'd0, 32'h1234);
    req_valid = 3'b001;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL x0_ready: got %b expected 001", req_ready); end
    step();
    issue_valid = 1'b0; req_valid = 3'b000;
    checks++; if (rf_reg_write !== 1'b0) begin errors++; $display("FAIL x0_we: got %b expected 0", rf_reg_write); end
    checks++; if (rf_rd !== 5'd12 || rf_write_data !== 32'hA2) begin errors++; $display("FAIL x0_hold: got rd=%0d data=%h expected rd=12 data=a2", rf_rd, rf_write_data); end
    checks++; if (busy_vec !== 32'h8) begin errors++; $display("FAIL x0_busy: got %h expected 8", busy_vec); end
    step();
    checks++; if (busy_vec !== 32'h8) begin errors++; $display("FAIL x0_busy_later: got %h expected 8", busy_vec); end
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    checks++; if (busy_vec !== 32'h88) begin errors++; $display("FAIL sb_busy_set: got %h expected 88", busy_vec); end
    rs1 = 5'd7; rs2 = 5'd0; #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sb_hazard_rs1: got %b expected 1", hazard); end
    rs1 = 5'd0; rs2 = 5'd3; #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sb_hazard_rs2: got %b expected 1", hazard); end
    rs1 = 5'd4; rs2 = 5'd5; #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL sb_no_hazard: got %b expected 0", hazard); end
    rs1 = 5'd7; rs2 = 5'd0;
    set_req(2, 5'd7, 32'h77);
    req_valid = 3'b100;
    #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL sb_wb_ready: got %b expected 100", req_ready); end
    step();
    req_valid = 3'b000;
    checks++; if (rf_reg_write !== 1'b1 || rf_rd !== 5'd7) begin errors++; $display("FAIL sb_wb_write: got we=%b rd=%0d expected we=1 rd=7", rf_reg_write, rf_rd); end
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sb_hazard_n1: got %b expected 1", hazard); end
    step();
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL sb_hazard_n2: got %b expected 0", hazard); end
    checks++; if (busy_vec !== 32'h8) begin errors++; $display("FAIL sb_busy_clr: got %h expected 8", busy_vec); end
    rs1 = 5'd0;
  endtask

  task automatic test_collision();
    set_req(0, 5'd9, 32'h99);
    req_valid = 3'b001;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL coll_ready: got %b expected 001", req_ready); end
    step();
    req_valid = 3'b000;
    issue_valid = 1'b1; issue_rd = 5'd9;
    checks++; if (rf_reg_write !== 1'b1 || rf_rd !== 5'd9) begin errors++; $display("FAIL coll_write: got we=%b rd=%0d expected we=1 rd=9", rf_reg_write, rf_rd); end
    step();
    issue_valid = 1'b0;
    checks++; if (busy_vec !== 32'h208) begin errors++; $display("FAIL coll_busy: got %h expected 208", busy_vec); end
    rs1 = 5'd9; #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL coll_hazard: got %b expected 1", hazard); end
    rs1 = 5'd0;
  endtask

  task automatic test_back_to_back();
    set_req(1, 5'd20, 32'h11110001);
    set_req(2, 5'd20, 32'h22220002);
    req_valid = 3'b110;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL b2b_first_ready: got %b expected 010", req_ready); end
    step();
    req_valid = 3'b100;
    checks++; if (rf_rd !== 5'd20 || rf_write_data !== 32'h11110001) begin errors++; $display("FAIL b2b_first: got rd=%0d data=%h expected rd=20 data=11110001", rf_rd, rf_write_data); end
    #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL b2b_second_ready: got %b expected 100", req_ready); end
    step();
    req_valid = 3'b000;
    checks++; if (rf_reg_write !== 1'b1 || rf_write_data !== 32'h22220002) begin errors++; $display("FAIL b2b_second: got we=%b data=%h expected we=1 data=22220002", rf_reg_write, rf_write_data); end
  endtask

  task automatic test_reset_midstream();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int r = 4; r < 8; r++) begin
      issue_valid = 1'b1; issue_rd = AW'(r);
      step();
    end
    issue_valid = 1'b0;
    checks++; if (busy_vec !== 32'hF0) begin errors++; $display("FAIL mid_busy_pre: got %h expected f0", busy_vec); end
    set_req(1, 5'd6, 32'h66);
    set_req(2, 5'd7, 32'h70);
    req_valid = 3'b110;
    step();
    req_valid = 3'b100;
    rs1 = 5'd4;
    checks++; if (rf_reg_write !== 1'b1) begin errors++; $display("FAIL mid_inflight_we: got %b expected 1", rf_reg_write); end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (rf_reg_write !== 1'b0 || rf_rd !== 5'd0 || rf_write_data !== 32'd0 || busy_vec !== 32'd0 || hazard !== 1'b0 || req_ready !== 3'b000) begin
      errors++;
      $display("FAIL mid_async_clear: got we=%b rd=%0d data=%h busy=%h hazard=%b ready=%b expected all zero",
               rf_reg_write, rf_rd, rf_write_data, busy_vec, hazard, req_ready);
    end
    step();
    checks++; if (rf_reg_write !== 1'b0) begin errors++; $display("FAIL mid_no_write_in_reset: got %b expected 0", rf_reg_write); end
    req_valid = 3'b000;
    rst = 1'b0;
    step();
    checks++; if (rf_reg_write !== 1'b0 || busy_vec !== 32'd0) begin errors++; $display("FAIL mid_after_release: got we=%b busy=%h expected we=0 busy=0", rf_reg_write, busy_vec); end
    rs1 = 5'd0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_x0();
    test_scoreboard();
    test_collision();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
